// File: rtl/instr_encoder_if.sv
// Instruction encoder bus interface.
// Carries the session control, the field-bundle handshake, the instruction
// memory write channel and the status flags between a producer (master) and
// the encoder (slave). Clock and reset stay outside as plain ports.
//   start_i            : session (re)start pulse
//   in_valid_i/ready_o : field bundle handshake
//   op_i..imm_i        : instruction fields
//   wr_*               : instruction memory write channel
//   count_o            : words written this session
//   busy_o/full_o/err_o: session active, memory full, sticky illegal flag
interface instr_encoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  start_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [2:0]            op_i;
  logic [2:0]            funct3_i;
  logic                  funct7_i;
  logic [4:0]            rd_i;
  logic [4:0]            rs1_i;
  logic [4:0]            rs2_i;
  logic [DATA_WIDTH-1:0] imm_i;
  logic                  wr_en_o;
  logic                  wr_ready_i;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic [ADDR_WIDTH-2:0] count_o;
  logic                  busy_o;
  logic                  full_o;
  logic                  err_o;

  modport slave (
    input  start_i, in_valid_i, op_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i,
           imm_i, wr_ready_i,
    output in_ready_o, wr_en_o, wr_addr_o, wr_data_o, count_o, busy_o,
           full_o, err_o
  );

  modport master (
    output start_i, in_valid_i, op_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i,
           imm_i, wr_ready_i,
    input  in_ready_o, wr_en_o, wr_addr_o, wr_data_o, count_o, busy_o,
           full_o, err_o
  );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder.
// Accepts RV32I-style field bundles, packs them into 32-bit instruction words
// and writes them sequentially into an instruction memory starting at byte
// address 0. Illegal bundles are consumed without a write and raise a sticky
// error flag. A session ends in FULL once every memory word has been written.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : instr_encoder_if slave (handshake, write channel, status)
module instr_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);

  localparam int DEPTH = (2 ** ADDR_WIDTH) / 4;
  localparam logic [ADDR_WIDTH-2:0] LAST_CNT = (ADDR_WIDTH-1)'(DEPTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  // Returns {illegal, word}. B and JAL immediates must be halfword aligned.
  function automatic logic [32:0] encode_fn(
    input logic [2:0]  op,
    input logic [2:0]  f3,
    input logic        f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [20:0] imm
  );
    logic [31:0] word;
    logic        bad;
    word = 32'h0000_0000;
    bad  = 1'b0;
    case (op)
      3'b000: word = {imm[11:0], rs1, f3, rd, 7'b0000011};
      3'b001: word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      3'b010: word = {1'b0, f7, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
      3'b011: begin
        // Shift-left-immediate carries only shamt in the immediate field.
        if (f3 == 3'b001) begin
          word = {7'b0000000, imm[4:0], rs1, f3, rd, 7'b0010011};
        end else begin
          word = {imm[11:0], rs1, f3, rd, 7'b0010011};
        end
      end
      3'b100: begin
        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
        bad  = imm[0];
      end
      3'b101: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        bad  = imm[0];
      end
      3'b110: word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      3'b111: bad = 1'b1;
      default: bad = 1'b1;
    endcase
    return {bad, word};
  endfunction

  logic [1:0]            state_r;
  logic                  wr_en_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic [ADDR_WIDTH-2:0] count_r;
  logic                  err_r;

  logic [32:0] enc_s;
  logic        room_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        complete_s;
  logic        unused_imm_s;

  // Immediate bits above 20 never reach any instruction format.
  assign unused_imm_s = ^bus.imm_i[DATA_WIDTH-1:21];

  // Encode the presented bundle and derive the handshake strobes.
  always_comb begin
    enc_s      = encode_fn(bus.op_i, bus.funct3_i, bus.funct7_i, bus.rd_i,
                           bus.rs1_i, bus.rs2_i, bus.imm_i[20:0]);
    // With the last free word already pending, a further bundle would have
    // nowhere to go: the pending completion moves the session to FULL.
    room_s     = !(wr_en_r && (count_r == LAST_CNT));
    in_ready_s = (state_r == RUN) && !bus.start_i &&
                 (!wr_en_r || bus.wr_ready_i) && room_s;
    accept_s   = bus.in_valid_i && in_ready_s;
    complete_s = wr_en_r && bus.wr_ready_i;
  end

  // Session state, pending write and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      count_r   <= '0;
      err_r     <= 1'b0;
    end else if (bus.start_i) begin
      state_r   <= RUN;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      count_r   <= '0;
      err_r     <= 1'b0;
    end else begin
      if (complete_s) begin
        count_r <= count_r + (ADDR_WIDTH-1)'(1'b1);
        // The final write leaves the address on the last word instead of
        // wrapping; only a new session returns it to 0.
        if (count_r == LAST_CNT) begin
          state_r <= FULL;
        end else begin
          wr_addr_r <= wr_addr_r + ADDR_WIDTH'(3'd4);
        end
      end
      if (accept_s && !enc_s[32]) begin
        wr_en_r   <= 1'b1;
        wr_data_r <= DATA_WIDTH'(enc_s[31:0]);
      end else if (complete_s) begin
        wr_en_r <= 1'b0;
      end
      if (accept_s && enc_s[32]) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.in_ready_o = in_ready_s;
  assign bus.wr_en_o    = wr_en_r;
  assign bus.wr_addr_o  = wr_addr_r;
  assign bus.wr_data_o  = wr_data_r;
  assign bus.count_o    = count_r;
  assign bus.busy_o     = (state_r == RUN);
  assign bus.full_o     = (state_r == FULL);
  assign bus.err_o      = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  instr_encoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [39:0] exp_q[$];
  int          issued = 0;
  bit          err_exp = 1'b0;
  bit          hold_prev = 1'b0;
  logic [39:0] held;
  logic [39:0] e;
  bit          rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] fld(input bit [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
  endfunction

  // Reference encoder: places each field arithmetically. Returns {legal, word}.
  function automatic bit [32:0] ref_enc(input int op, input int f3, input int f7,
                                        input int rd, input int rs1, input int rs2,
                                        input bit [31:0] imm);
    bit [31:0] w;
    bit ok;
    bit [31:0] urd, uf3, urs1, urs2;
    urd = rd; uf3 = f3; urs1 = rs1; urs2 = rs2;
    ok = 1'b1;
    w  = 32'h0;
    case (op)
      0: w = 32'h03 + (urd << 7) + (uf3 << 12) + (urs1 << 15) + (fld(imm, 11, 0) << 20);
      1: w = 32'h23 + (fld(imm, 4, 0) << 7) + (uf3 << 12) + (urs1 << 15) + (urs2 << 20)
             + (fld(imm, 11, 5) << 25);
      2: w = 32'h33 + (urd << 7) + (uf3 << 12) + (urs1 << 15) + (urs2 << 20)
             + ((f7 != 0) ? 32'h4000_0000 : 32'h0);
      3: w = 32'h13 + (urd << 7) + (uf3 << 12) + (urs1 << 15)
             + (((f3 == 1) ? fld(imm, 4, 0) : fld(imm, 11, 0)) << 20);
      4: begin
        w = 32'h63 + (fld(imm, 11, 11) << 7) + (fld(imm, 4, 1) << 8) + (uf3 << 12)
            + (urs1 << 15) + (urs2 << 20) + (fld(imm, 10, 5) << 25) + (fld(imm, 12, 12) << 31);
        ok = (imm % 2) == 0;
      end
      5: begin
        w = 32'h6F + (urd << 7) + (fld(imm, 19, 12) << 12) + (fld(imm, 11, 11) << 20)
            + (fld(imm, 10, 1) << 21) + (fld(imm, 20, 20) << 31);
        ok = (imm % 2) == 0;
      end
      6: w = 32'h67 + (urd << 7) + (urs1 << 15) + (fld(imm, 11, 0) << 20);
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  // Monitor: pops the scoreboard whenever a write completes; checks holds.
  always @(negedge clk) begin
    if (!rst_n || bus.start_i) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_wr_en", {31'b0, bus.wr_en_o}, 32'h1);
        chk("hold_wr_addr", {24'b0, bus.wr_addr_o}, {24'b0, held[39:32]});
        chk("hold_wr_data", bus.wr_data_o, held[31:0]);
      end
      if (bus.wr_en_o && bus.wr_ready_i) begin
        hold_prev = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_write: addr 0x%02h data 0x%08h, no write expected",
                   bus.wr_addr_o, bus.wr_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {24'b0, bus.wr_addr_o}, {24'b0, e[39:32]});
          chk("wr_data", bus.wr_data_o, e[31:0]);
        end
      end else if (bus.wr_en_o) begin
        hold_prev = 1'b1;
        held = {bus.wr_addr_o, bus.wr_data_o};
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  // Random write backpressure, applied away from the directed drive slot.
  always @(posedge clk) begin
    #2;
    if (rdy_rand) bus.wr_ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int op, input int f3, input int f7, input int rd,
                      input int rs1, input int rs2, input bit [31:0] imm);
    bit [32:0] r;
    bit got;
    bus.op_i = 3'(op); bus.funct3_i = 3'(f3); bus.funct7_i = 1'(f7);
    bus.rd_i = 5'(rd); bus.rs1_i = 5'(rs1); bus.rs2_i = 5'(rs2); bus.imm_i = imm;
    bus.in_valid_i = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        got = 1'b1;
        r = ref_enc(op, f3, f7, rd, rs1, rs2, imm);
        if (r[32]) begin
          exp_q.push_back({8'(issued * 4), r[31:0]});
          issued++;
        end else begin
          err_exp = 1'b1;
        end
      end
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready_o stayed 0, expected 1 within 300 cycles");
    end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic rand_send(input bit legal_only);
    int op;
    bit [31:0] imm;
    op  = legal_only ? $urandom_range(0, 6) : $urandom_range(0, 7);
    imm = $urandom;
    if (legal_only && (op == 4 || op == 5)) imm[0] = 1'b0;
    send(op, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 31), imm);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.wr_en_o) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d writes still outstanding, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    exp_q.delete();
    issued  = 0;
    err_exp = 1'b0;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic session_check(input string tag);
    chk({tag, "_count"}, {25'b0, bus.count_o}, 32'(issued));
    chk({tag, "_err"}, {31'b0, bus.err_o}, {31'b0, err_exp});
    chk({tag, "_busy"}, {31'b0, bus.busy_o}, (issued < DEPTH) ? 32'h1 : 32'h0);
    chk({tag, "_full"}, {31'b0, bus.full_o}, (issued == DEPTH) ? 32'h1 : 32'h0);
    if (issued < DEPTH) chk({tag, "_addr"}, {24'b0, bus.wr_addr_o}, 32'(issued * 4));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, {31'b0, bus.in_ready_o}, 32'h0);
    chk({tag, "_wr_en"}, {31'b0, bus.wr_en_o}, 32'h0);
    chk({tag, "_wr_addr"}, {24'b0, bus.wr_addr_o}, 32'h0);
    chk({tag, "_wr_data"}, bus.wr_data_o, 32'h0);
    chk({tag, "_count"}, {25'b0, bus.count_o}, 32'h0);
    chk({tag, "_busy"}, {31'b0, bus.busy_o}, 32'h0);
    chk({tag, "_full"}, {31'b0, bus.full_o}, 32'h0);
    chk({tag, "_err"}, {31'b0, bus.err_o}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0; bus.in_valid_i = 1'b0; bus.op_i = 3'b000; bus.funct3_i = 3'b000;
    bus.funct7_i = 1'b0; bus.rd_i = 5'd0; bus.rs1_i = 5'd0; bus.rs2_i = 5'd0;
    bus.imm_i = 32'h0; bus.wr_ready_i = 1'b0;

    // Reset state, and IDLE ignores a valid bundle.
    #12;
    chk_all_zero("reset");
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_in_ready", {31'b0, bus.in_ready_o}, 32'h0);
    chk("idle_busy", {31'b0, bus.busy_o}, 32'h0);
    bus.in_valid_i = 1'b0;

    // Directed encodings.
    do_start();
    chk("start_busy", {31'b0, bus.busy_o}, 32'h1);
    bus.wr_ready_i = 1'b1;
    send(3, 0, 0, 1, 0, 0, 32'd5);
    chk("addi_wr_en", {31'b0, bus.wr_en_o}, 32'h1);
    chk("addi_addr", {24'b0, bus.wr_addr_o}, 32'h00);
    chk("addi_data", bus.wr_data_o, 32'h0050_0093);
    send(2, 0, 1, 3, 1, 2, 32'd0);
    chk("sub_addr", {24'b0, bus.wr_addr_o}, 32'h04);
    chk("sub_data", bus.wr_data_o, 32'h4020_81B3);
    send(4, 0, 0, 0, 1, 2, -32'sd8);
    chk("beq_data", bus.wr_data_o, 32'hFE20_8CE3);
    send(4, 0, 0, 0, 1, 2, -32'sd7);
    drain();
    chk("beq_odd_err", {31'b0, bus.err_o}, 32'h1);
    chk("beq_odd_count", {25'b0, bus.count_o}, 32'd3);
    session_check("directed");

    // Backpressure: write held for 3 cycles.
    bus.wr_ready_i = 1'b0;
    send(3, 0, 0, 5, 0, 0, 32'd7);
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, bus.in_ready_o}, 32'h0);
    end
    @(posedge clk); #1;
    bus.wr_ready_i = 1'b1;
    drain();
    chk("stall_count", {25'b0, bus.count_o}, 32'd4);

    // Randomized sessions including illegal bundles.
    for (int s = 0; s < 3; s++) begin
      do_start();
      rdy_rand = 1'b1;
      repeat (25) rand_send(1'b0);
      drain();
      rdy_rand = 1'b0;
      session_check("random");
    end

    // Fill the memory, then restart.
    do_start();
    rdy_rand = 1'b1;
    repeat (DEPTH) rand_send(1'b1);
    drain();
    rdy_rand = 1'b0;
    session_check("fill");
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    chk("full_in_ready", {31'b0, bus.in_ready_o}, 32'h0);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    do_start();
    chk("restart_count", {25'b0, bus.count_o}, 32'h0);
    chk("restart_full", {31'b0, bus.full_o}, 32'h0);
    chk("restart_busy", {31'b0, bus.busy_o}, 32'h1);
    bus.wr_ready_i = 1'b1;
    send(0, 2, 0, 7, 3, 0, 32'h0000_0010);
    chk("restart_addr", {24'b0, bus.wr_addr_o}, 32'h00);
    drain();
    session_check("restart");

    // Asynchronous reset while a write is pending.
    bus.wr_ready_i = 1'b0;
    send(3, 0, 0, 1, 0, 0, 32'd5);
    chk("prereset_wr_en", {31'b0, bus.wr_en_o}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    exp_q.delete();
    issued  = 0;
    err_exp = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.wr_ready_i = 1'b1;
    bus.in_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("postreset_in_ready", {31'b0, bus.in_ready_o}, 32'h0);
      chk("postreset_wr_en", {31'b0, bus.wr_en_o}, 32'h0);
    end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    do_start();
    send(2, 0, 1, 3, 1, 2, 32'd0);
    drain();
    session_check("after_reset");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
